// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, key-to-matrix mapping, legality check, FSM encoding.
// Used by the emulator and by scanner-side checkers.
package keypad_pkg;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_BOUNCE_IN  = 3'd1,
        ST_PRESS      = 3'd2,
        ST_BOUNCE_OUT = 3'd3,
        ST_RELEASE    = 3'd4,
        ST_GAP        = 3'd5
    } state_t;

    function automatic logic key_illegal(input logic [3:0] key);
        return key > KEY_HASH;
    endfunction

    // Row line (0..3) that a key closes onto.
    function automatic logic [1:0] key_row(input logic [3:0] key);
        logic [1:0] r;
        case (key)
            4'd1, 4'd2, 4'd3: r = 2'd0;
            4'd4, 4'd5, 4'd6: r = 2'd1;
            4'd7, 4'd8, 4'd9: r = 2'd2;
            default:          r = 2'd3;
        endcase
        return r;
    endfunction

    // Column line (0..2) that a key closes onto.
    function automatic logic [1:0] key_col(input logic [3:0] key);
        logic [1:0] c;
        case (key)
            4'd1, 4'd4, 4'd7, KEY_STAR: c = 2'd0;
            4'd2, 4'd5, 4'd8, 4'd0:     c = 2'd1;
            default:                    c = 2'd2;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/keypad_bounce_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) driving contact bounce.
// Only built when KEYPAD_BOUNCE_EN is defined.
`ifdef KEYPAD_BOUNCE_EN
module keypad_bounce_lfsr
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= LFSR_SEED;
        end else if (en) begin
            value <= {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
        end
    end

endmodule
`endif

// File: rtl/keypad_emulator.sv
// 3x4 matrix keypad emulator: accepts press commands and closes row/column contacts.
// Optional contact bounce around each press is enabled by defining KEYPAD_BOUNCE_EN.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned HOLD_W        = 16,
    parameter int unsigned GAP_CYCLES    = 8,
    parameter int unsigned BOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        column,
    output logic [3:0]        row,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_key,
    input  logic [HOLD_W-1:0] cmd_hold,
    output logic              busy,
    output logic              pressed,
    output logic              cmd_err
);

    // One window counter serves both the bounce windows and the post-press gap.
    localparam int unsigned CNT_MAX = (GAP_CYCLES > BOUNCE_CYCLES) ? GAP_CYCLES : BOUNCE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

`ifdef KEYPAD_BOUNCE_EN
    localparam state_t PRESS_ENTRY = ST_BOUNCE_IN;
    localparam state_t PRESS_EXIT  = ST_BOUNCE_OUT;

    logic [7:0] lfsr;

    keypad_bounce_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .value (lfsr)
    );
`else
    localparam state_t PRESS_ENTRY = ST_PRESS;
    localparam state_t PRESS_EXIT  = ST_RELEASE;
`endif

    localparam logic [CNT_W-1:0] EXIT_LOAD = (PRESS_EXIT == ST_RELEASE) ?
                                             CNT_W'(GAP_CYCLES) : CNT_W'(BOUNCE_CYCLES);

    state_t            state, state_next;
    logic [HOLD_W-1:0] hold_cnt, hold_next;
    logic [CNT_W-1:0]  aux_cnt, aux_next;
    logic [3:0]        key_q, key_next;
    logic              ready_next, busy_next, pressed_next, err_next;
    logic [3:0]        row_next;
    logic              xfer;
    logic              col_bit;

    assign xfer = cmd_valid && cmd_ready;

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            aux_cnt   <= '0;
            key_q     <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            pressed   <= 1'b0;
            cmd_err   <= 1'b0;
            row       <= 4'b1111;
        end else begin
            state     <= state_next;
            hold_cnt  <= hold_next;
            aux_cnt   <= aux_next;
            key_q     <= key_next;
            cmd_ready <= ready_next;
            busy      <= busy_next;
            pressed   <= pressed_next;
            cmd_err   <= err_next;
            row       <= row_next;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        aux_next   = aux_cnt;
        key_next   = key_q;
        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    key_next  = cmd_key;
                    hold_next = (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;
                    if (key_illegal(cmd_key)) begin
                        state_next = ST_GAP;
                        aux_next   = CNT_W'(GAP_CYCLES);
                    end else begin
                        state_next = PRESS_ENTRY;
                        aux_next   = CNT_W'(BOUNCE_CYCLES);
                    end
                end
            end
            ST_BOUNCE_IN: begin
                if (aux_cnt <= CNT_W'(1)) state_next = ST_PRESS;
                else                      aux_next   = aux_cnt - CNT_W'(1);
            end
            ST_PRESS: begin
                if (hold_cnt <= HOLD_W'(1)) begin
                    state_next = PRESS_EXIT;
                    aux_next   = EXIT_LOAD;
                end else begin
                    hold_next = hold_cnt - HOLD_W'(1);
                end
            end
            ST_BOUNCE_OUT: begin
                if (aux_cnt <= CNT_W'(1)) begin
                    state_next = ST_RELEASE;
                    aux_next   = CNT_W'(GAP_CYCLES);
                end else begin
                    aux_next = aux_cnt - CNT_W'(1);
                end
            end
            ST_RELEASE, ST_GAP: begin
                if (aux_cnt <= CNT_W'(1)) state_next = ST_IDLE;
                else                      aux_next   = aux_cnt - CNT_W'(1);
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode; row reflects the contact as it stood during the current cycle.
    always_comb begin
        ready_next   = (state_next == ST_IDLE);
        busy_next    = (state_next != ST_IDLE);
        pressed_next = (state_next == ST_PRESS);
`ifdef KEYPAD_BOUNCE_EN
        if (state_next == ST_BOUNCE_IN || state_next == ST_BOUNCE_OUT) pressed_next = lfsr[0];
`endif
        err_next = xfer && key_illegal(cmd_key);

        case (key_col(key_q))
            2'd0:    col_bit = column[0];
            2'd1:    col_bit = column[1];
            default: col_bit = column[2];
        endcase

        row_next = 4'b1111;
        if (pressed && !col_bit) row_next[key_row(key_q)] = 1'b0;
    end

endmodule
